// File: rtl/seq_comp.sv
// seq_comp: constant-time multi-cycle masked equality comparator for the verify path
module seq_comp #(
  parameter int DATA_W  = 256,
  parameter int SIG_W   = 160,
  parameter int CHUNK_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic              equal
);
  localparam int N  = DATA_W / CHUNK_W;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [DATA_W-1:0] SIG_MASK = {DATA_W{1'b1}} >> (DATA_W - SIG_W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [DATA_W-1:0] a_q, b_q, mask;
  logic              mode_q;
  logic [IW-1:0]     idx;
  logic [CHUNK_W-1:0] acc, diff;
  // masked difference of the chunk selected by idx; mask depends only on latched mode
  always_comb begin
    mask = mode_q ? '1 : SIG_MASK;
    diff = (a_q[idx*CHUNK_W +: CHUNK_W] ^ b_q[idx*CHUNK_W +: CHUNK_W]) & mask[idx*CHUNK_W +: CHUNK_W];
  end
  // fixed-length compare sequence with zeroize on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      equal  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      idx    <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= op_a;
            b_q    <= op_b;
            mode_q <= mode;
            idx    <= '0;
            acc    <= '0;
            equal  <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc | diff;
          idx <= idx + 1'b1;
          if (idx == IW'(N - 1)) begin
            equal <= ~|(acc | diff);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done   <= 1'b0;
          busy   <= 1'b0;
          a_q    <= '0;
          b_q    <= '0;
          mode_q <= 1'b0;
          acc    <= '0;
          idx    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_comp.sv
// tb_seq_comp: scoreboard bench for seq_comp at default parameters
module tb_seq_comp;
  localparam int DATA_W = 256;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, mode = 1'b0;
  logic [DATA_W-1:0] op_a = '0, op_b = '0, base;
  logic busy, done, equal;
  int checks = 0, errors = 0, cyc = 0;
  logic exp_q[$];
  int cyc_q[$];

  seq_comp dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .equal(equal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_done", 1, 0);
      else begin
        check("equal", equal, exp_q.pop_front());
        check("latency", cyc - cyc_q.pop_front(), N);
      end
    end
  end

  task automatic run_cmp(input logic m, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic exp, input int restart_at);
    start = 1'b1; mode = m; op_a = a; op_b = b;
    tick();
    start = 1'b0;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc);
    check("busy_e0", busy, 1);
    check("equal_failsafe", equal, 0);
    for (int i = 1; i <= N; i++) begin
      if (i == restart_at) begin
        start = 1'b1; mode = ~m; op_a = ~a; op_b = a;
      end
      tick();
      start = 1'b0;
      op_a = $urandom; op_b = $urandom;
      check("done_timing", done, i == N);
      check("busy_run", busy, 1);
    end
    tick();
    check("done_clear", done, 0);
    check("busy_clear", busy, 0);
  endtask

  initial begin
    base = {DATA_W / 32{32'h3C5A_96E1}};
    rst = 1'b1;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_equal", equal, 0);
    tick();
    rst = 1'b0;
    tick();
    run_cmp(1'b1, {32{8'hA5}}, {32{8'hA5}}, 1'b1, -1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("equal_hold", equal, 1);
    end
    run_cmp(1'b1, base, base ^ (256'd1 << 255), 1'b0, -1);
    run_cmp(1'b1, base, base ^ 256'd1, 1'b0, -1);
    run_cmp(1'b0, base, base ^ (256'd1 << 200), 1'b1, -1);
    run_cmp(1'b0, base, base ^ (256'd1 << 159), 1'b0, -1);
    run_cmp(1'b1, base ^ (256'd1 << 100), base, 1'b0, -1);
    run_cmp(1'b0, base, base, 1'b1, 3);
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; mode = 1'b1; op_a = base; op_b = base;
    tick();
    start = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_equal", equal, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    run_cmp(1'b1, base, base, 1'b1, -1);
    for (int i = 0; i < 3; i++) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
